// File: rtl/alu_reservation_station.sv
// Reservation-station bank for the ALU: holds issued instructions, snoops the CDB
// for pending operands, and presents the lowest-index ready entry to the ALU.
module alu_reservation_station #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  TAG_BASE = 8'd1,
    parameter int unsigned OP_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    output logic [7:0]        issue_tag,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [7:0]        issue_qj,
    input  logic [7:0]        issue_qk,
    input  logic [31:0]       issue_vj,
    input  logic [31:0]       issue_vk,
    input  logic [40:0]       cdb,
    output logic              fu_valid,
    input  logic              fu_ready,
    output logic [OP_W-1:0]   fu_op,
    output logic [31:0]       fu_a,
    output logic [31:0]       fu_b,
    output logic [7:0]        fu_tag
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned DATA_W = 32;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    assign cdb_valid = cdb[40];
    assign cdb_tag   = cdb[39:32];
    assign cdb_data  = cdb[31:0];

    logic [DEPTH-1:0]  busy;
    logic [OP_W-1:0]   op_q [DEPTH];
    logic [TAG_W-1:0]  qj_q [DEPTH];
    logic [TAG_W-1:0]  qk_q [DEPTH];
    logic [DATA_W-1:0] vj_q [DEPTH];
    logic [DATA_W-1:0] vk_q [DEPTH];

    logic [DEPTH-1:0]  ready;
    logic [IDX_W-1:0]  free_idx;
    logic              free_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              issue_fire;
    logic              dispatch_fire;

    logic [TAG_W-1:0]  fwd_qj;
    logic [TAG_W-1:0]  fwd_qk;
    logic [DATA_W-1:0] fwd_vj;
    logic [DATA_W-1:0] fwd_vk;

    // Ready entries and lowest-index free/ready selection from registered state
    always_comb begin
        ready      = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel_idx    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ready[i] = busy[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign issue_ready   = free_found;
    assign issue_tag     = free_found ? (TAG_BASE + TAG_W'(free_idx)) : '0;
    assign fu_valid      = |ready;
    assign fu_op         = op_q[sel_idx];
    assign fu_a          = vj_q[sel_idx];
    assign fu_b          = vk_q[sel_idx];
    assign fu_tag        = TAG_BASE + TAG_W'(sel_idx);
    assign issue_fire    = issue_valid && free_found;
    assign dispatch_fire = fu_valid && fu_ready;

    // Operand forwarding from a CDB broadcast landing in the issue cycle
    always_comb begin
        fwd_qj = issue_qj;
        fwd_vj = issue_vj;
        fwd_qk = issue_qk;
        fwd_vk = issue_vk;
        if (cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag)) begin
            fwd_qj = '0;
            fwd_vj = cdb_data;
        end
        if (cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag)) begin
            fwd_qk = '0;
            fwd_vk = cdb_data;
        end
    end

    // Issue only targets a free entry, so snoop/dispatch/issue never collide
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                qj_q[i] <= '0;
                qk_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (busy[i] && cdb_valid && (qj_q[i] != '0) && (qj_q[i] == cdb_tag)) begin
                    qj_q[i] <= '0;
                    vj_q[i] <= cdb_data;
                end
                if (busy[i] && cdb_valid && (qk_q[i] != '0) && (qk_q[i] == cdb_tag)) begin
                    qk_q[i] <= '0;
                    vk_q[i] <= cdb_data;
                end
            end
            if (dispatch_fire) begin
                busy[sel_idx] <= 1'b0;
            end
            if (issue_fire) begin
                busy[free_idx] <= 1'b1;
                op_q[free_idx] <= issue_op;
                qj_q[free_idx] <= fwd_qj;
                qk_q[free_idx] <= fwd_qk;
                vj_q[free_idx] <= fwd_vj;
                vk_q[free_idx] <= fwd_vk;
            end
        end
    end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Reservation-station bank for the ALU functional unit. It accepts issued instructions with source operands that are either values or producer tags. It snoops the broadcast common data bus to capture pending operands by tag match, and dispatches the lowest-index ready entry to the ALU. It is the consumer end of the CDB: the arbiter drives the bus, and this block reads it.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_BASE, 8'd1, tag of entry 0; entry i owns tag TAG_BASE+i; tag 8'd0 is reserved as "operand ready"
- OP_W, 5, opcode width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset; sampled on posedge clk
- issue_valid  in  1  issue request
- issue_ready  out  1  at least one free entry
- issue_tag  out  8  tag assigned to the current issue (TAG_BASE + lowest free index); 0 when full
- issue_op  in  OP_W  opcode
- issue_qj, issue_qk  in  8  producer tags of sources (0 = value valid)
- issue_vj, issue_vk  in  32  source values (meaningful when the matching q is 0)
- cdb  in  41  [40] valid, [39:32] tag, [31:0] data
- fu_valid  out  1  a ready entry is presented
- fu_ready  in  1  ALU accepts
- fu_op  out  OP_W  opcode of presented entry
- fu_a, fu_b  out  32  operands of presented entry
- fu_tag  out  8  tag of presented entry (ALU returns it on its CDB request)

## Operation
- Each entry holds busy, op, qj, qk, vj, vk.
- Entry ready: busy && qj==0 && qk==0, evaluated on registered state.
- Issue:
  - issue_ready = |~busy.
  - Accept on issue_valid && issue_ready into the lowest free index.
  - Fields are written from the issue inputs, with same-cycle forwarding: if cdb[40] && issue_qj==cdb[39:32] && issue_qj!=0, store qj=0 and vj=cdb[31:0]. qk is handled the same way.
- CDB snoop, every cycle, for every busy entry independently:
  - if cdb[40] && qj==cdb[39:32] && qj!=0: qj<=0, vj<=cdb[31:0]; same for qk.
  - With cdb[40]=0, tags and data are ignored.
- Dispatch:
  - fu_valid = any ready entry; the presented entry is the lowest ready index. fu_* outputs are combinational from the registers.
  - On fu_valid && fu_ready, the presented entry's busy<=0. Other fields keep stale values.
- Simultaneous events:
  - Dispatch frees entry i in the same cycle an issue allocates: allocation uses pre-update busy, so the freed entry is not reusable until the next cycle.
  - An issue and a CDB capture never target the same entry, because issue writes only a non-busy entry.
- Issue with issue_valid && !issue_ready is ignored; no state change.
- Reset (rst==0 at posedge): all busy<=0, all q<=0. Outputs become fu_valid=0, issue_ready=1, issue_tag=TAG_BASE. Reset mid-operation discards all entries, including any pending dispatch.

## Timing
- Issue with both operands ready: fu_valid asserts the cycle after the accepting edge (1-cycle latency).
- CDB capture at edge N: entry ready, fu_valid high after edge N (next cycle).
- Same-cycle forwarding at issue behaves identically to issue with ready operands.
- fu_* outputs hold stable while fu_valid && !fu_ready unless a lower-index entry becomes ready. Lower-index priority may switch the presented entry; the ALU must sample fu_* only on the handshake cycle.
- No combinational path from fu_ready to fu_valid or issue_ready.

## Test plan
- Reset: hold rst=0 two cycles with issue_valid=1 -> after release, fu_valid=0, issue_ready=1, issue_tag=1; no entry allocated.
- Ready issue: op=3, qj=qk=0, vj=5, vk=7, fu_ready=1 -> next cycle fu_valid=1, fu_op=3, fu_a=5, fu_b=7, fu_tag=1; entry freed after handshake.
- Pending capture: issue qj=8'h12, vk=9 (qk=0); two cycles later cdb={1,8'h12,32'hDEAD_BEEF} -> fu_valid the following cycle with fu_a=32'hDEAD_BEEF, fu_b=9. An earlier cdb={0,8'h12,x} causes no capture.
- Forwarding: issue qj=8'h20 in the same cycle as cdb={1,8'h20,32'h44} -> fu_valid next cycle, fu_a=32'h44.
- Full/stall: fu_ready=0, issue 4 ready instructions -> tags 1,2,3,4; issue_ready=0 and issue_tag=0 after the 4th; a 5th request is ignored. Raise fu_ready -> dispatch order is tags 1,2,3,4; issue_ready=1 one cycle after the first handshake.
- Reset mid-operation: 3 busy entries and fu_valid=1, pulse rst=0 for one cycle -> fu_valid=0, issue_ready=1, no dispatch of old entries.
